// File: rtl/opb_status_bank.sv
// OPB slave exposing a bank of user-channel snapshot registers with a
// freeze control, sticky missed-snapshot flag and snapshot counter.
module opb_status_bank #(
    parameter logic [31:0] C_BASEADDR   = 32'h01000100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010001FF,
    parameter int          C_NUM_REGS   = 4,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst,
    input  logic [0:31]              OPB_ABus,
    input  logic [0:3]               OPB_BE,
    input  logic [0:31]              OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:31]              Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_errAck,
    output logic                     Sl_retry,
    output logic                     Sl_toutSup,
    input  logic [C_NUM_REGS*32-1:0] user_data_in,
    input  logic                     user_valid
);

    logic [31:0] shadow [C_NUM_REGS];
    logic [31:0] snap_cnt;
    logic        freeze;
    logic        missed;

    logic        ack_p1;
    logic [31:0] rd_data_p1;
    logic        wr_pend_p1;
    logic        wr_freeze_p1;
    logic        wr_clr_p1;

    logic        hit;
    logic        start;
    logic [31:0] word_idx;
    logic [31:0] rd_mux;
    logic        snap_take;
    logic        snap_miss;

    assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    // A hit that lands on the ack cycle is the tail of the same transfer, not a new one.
    assign start    = hit && !ack_p1;
    assign word_idx = (OPB_ABus - C_BASEADDR) >> 2;

    assign snap_take = user_valid && !freeze;
    assign snap_miss = user_valid && freeze;

    always_comb begin
        rd_mux = '0;
        if (word_idx == 32'd0) begin
            rd_mux = {30'd0, missed, freeze};
        end else if (word_idx == 32'd1) begin
            rd_mux = snap_cnt;
        end else begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                if (word_idx == 32'(k + 2)) begin
                    rd_mux = shadow[k];
                end
            end
        end
    end

    // Stage p1: hit captured, ack and read data presented
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            ack_p1       <= 1'b0;
            rd_data_p1   <= '0;
            wr_pend_p1   <= 1'b0;
            wr_freeze_p1 <= 1'b0;
            wr_clr_p1    <= 1'b0;
        end else begin
            ack_p1       <= start;
            rd_data_p1   <= start ? rd_mux : 32'd0;
            wr_pend_p1   <= start && !OPB_RNW && OPB_BE[3] && (word_idx == 32'd0);
            wr_freeze_p1 <= OPB_DBus[31];
            wr_clr_p1    <= OPB_DBus[30];
        end
    end

    // Register bank: the CTRL write commits at the end of the ack cycle
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                shadow[k] <= '0;
            end
            snap_cnt <= '0;
            freeze   <= 1'b0;
            missed   <= 1'b0;
        end else begin
            if (snap_take) begin
                for (int k = 0; k < C_NUM_REGS; k++) begin
                    shadow[k] <= user_data_in[32*k +: 32];
                end
                snap_cnt <= snap_cnt + 32'd1;
            end
            if (ack_p1 && wr_pend_p1) begin
                freeze <= wr_freeze_p1;
            end
            if (snap_miss) begin
                missed <= 1'b1;
            end else if (ack_p1 && wr_pend_p1 && wr_clr_p1) begin
                missed <= 1'b0;
            end
        end
    end

    assign Sl_DBus    = rd_data_p1;
    assign Sl_xferAck = ack_p1;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29],
                         C_OPB_AWIDTH, C_OPB_DWIDTH, C_FAMILY};

endmodule

// File: tb/tb_opb_status_bank.sv
// Randomized self-checking bench for opb_status_bank against a register-level
// reference model of the CTRL / SNAP_CNT / shadow map.
module tb_opb_status_bank;

    localparam logic [31:0] BASE = 32'h01000100;
    localparam logic [31:0] HIGH = 32'h010001FF;
    localparam int          NREG = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [0:31]       abus;
    logic [0:3]        be;
    logic [0:31]       dbus;
    logic              rnw;
    logic              sel;
    logic              seq_addr;
    logic [0:31]       sl_dbus;
    logic              sl_ack;
    logic              sl_err;
    logic              sl_retry;
    logic              sl_tout;
    logic [NREG*32-1:0] udata;
    logic              uvalid;

    int checks   = 0;
    int failures = 0;

    opb_status_bank dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seq_addr),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (sl_ack),
        .Sl_errAck    (sl_err),
        .Sl_retry     (sl_retry),
        .Sl_toutSup   (sl_tout),
        .user_data_in (udata),
        .user_valid   (uvalid)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic        m_freeze;
    logic        m_missed;
    logic [31:0] m_cnt;
    logic [31:0] m_sh [NREG];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int w);
        if (w == 0) return {30'd0, m_missed, m_freeze};
        if (w == 1) return m_cnt;
        if (w >= 2 && w < NREG + 2) return m_sh[w-2];
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_freeze = 1'b0;
        m_missed = 1'b0;
        m_cnt    = 32'd0;
        for (int k = 0; k < NREG; k++) m_sh[k] = 32'd0;
    endtask

    task automatic model_snap(input logic [NREG*32-1:0] d);
        if (!m_freeze) begin
            for (int k = 0; k < NREG; k++) m_sh[k] = d[32*k +: 32];
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_missed = 1'b1;
        end
    endtask

    function automatic logic [NREG*32-1:0] rand_data();
        logic [NREG*32-1:0] d;
        for (int k = 0; k < NREG; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    task automatic snap_pulse(input logic [NREG*32-1:0] d);
        @(posedge clk) #1;
        uvalid = 1'b1;
        udata  = d;
        @(posedge clk) #1;
        uvalid = 1'b0;
        model_snap(d);
    endtask

    // One OPB transfer; uv pulses user_valid in the hit cycle for reads and in
    // the ack cycle for writes.
    task automatic xfer(input int w, input logic r, input logic [31:0] wd,
                        input logic [3:0] b, input logic uv,
                        input logic [NREG*32-1:0] ud, output logic [31:0] rd);
        logic [31:0] exp;
        logic        set_m;
        @(posedge clk) #1;
        abus = BASE + 32'(4 * w);
        rnw  = r;
        dbus = wd;
        be   = b;
        sel  = 1'b1;
        if (r && uv) begin
            uvalid = 1'b1;
            udata  = ud;
        end
        exp = exp_word(w);
        @(negedge clk);
        chk("ack_hit_cycle", 32'(sl_ack), 32'd0);
        chk("dbus_hit_cycle", sl_dbus, 32'd0);
        @(posedge clk) #1;
        uvalid = 1'b0;
        if (!r && uv) begin
            uvalid = 1'b1;
            udata  = ud;
        end
        @(negedge clk);
        chk("ack_pulse", 32'(sl_ack), 32'd1);
        rd = sl_dbus;
        if (r) chk($sformatf("rd_word%0d", w), rd, exp);
        @(posedge clk) #1;
        sel    = 1'b0;
        uvalid = 1'b0;
        rnw    = 1'b1;
        @(negedge clk);
        chk("ack_width", 32'(sl_ack), 32'd0);
        chk("dbus_idle", sl_dbus, 32'd0);
        if (r) begin
            if (uv) model_snap(ud);
        end else begin
            set_m = uv && m_freeze;
            if (uv) model_snap(ud);
            if (b[0] && w == 0) begin
                m_freeze = wd[0];
                if (wd[1] && !set_m) m_missed = 1'b0;
            end
        end
    endtask

    task automatic rd_chk(input int w);
        logic [31:0] d;
        xfer(w, 1'b1, 32'd0, 4'hF, 1'b0, '0, d);
    endtask

    task automatic wr(input int w, input logic [31:0] wd, input logic [3:0] b);
        logic [31:0] d;
        xfer(w, 1'b0, wd, b, 1'b0, '0, d);
    endtask

    task automatic miss_access(input logic [31:0] a, input logic r);
        @(posedge clk) #1;
        abus = a;
        rnw  = r;
        dbus = 32'h00000003;
        be   = 4'hF;
        sel  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("miss_no_ack", 32'(sl_ack), 32'd0);
            if (i < 2) @(posedge clk) #1;
        end
        @(posedge clk) #1;
        sel = 1'b0;
    endtask

    initial begin
        logic [31:0]        d;
        logic [5:0]         pat;
        logic [NREG*32-1:0] ud;
        int                 op;
        int                 w;

        rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b1; sel = 1'b0;
        seq_addr = 1'b0; udata = '0; uvalid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", 32'(sl_ack), 32'd0);
        chk("reset_dbus", sl_dbus, 32'd0);
        chk("tied_outputs", {29'd0, sl_err, sl_retry, sl_tout}, 32'd0);
        @(posedge clk) #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) rd_chk(i);

        ud = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        snap_pulse(ud);
        for (int i = 1; i < 6; i++) rd_chk(i);

        wr(0, 32'h00000001, 4'hF);
        snap_pulse(rand_data());
        for (int i = 0; i < 6; i++) rd_chk(i);
        wr(0, 32'h00000002, 4'hF);
        rd_chk(0);

        // Freeze write racing a strobe: old freeze governs, set beats clear
        wr(0, 32'h00000001, 4'hF);
        xfer(0, 1'b0, 32'h00000002, 4'hF, 1'b1, rand_data(), d);
        for (int i = 0; i < 6; i++) rd_chk(i);
        wr(0, 32'h00000002, 4'hF);

        // Snapshot counter wrap via backdoor
        @(negedge clk);
        force dut.snap_cnt = 32'hFFFFFFFF;
        #1;
        release dut.snap_cnt;
        m_cnt = 32'hFFFFFFFF;
        rd_chk(1);
        snap_pulse(rand_data());
        rd_chk(1);

        // Held select on word 2: ack every other cycle
        @(posedge clk) #1;
        abus = BASE + 32'd8;
        rnw  = 1'b1;
        sel  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[5-i] = sl_ack;
            if (i < 5) @(posedge clk) #1;
        end
        @(posedge clk) #1;
        sel = 1'b0;
        chk("held_select_acks", 32'(pat), 32'(6'b010101));
        @(negedge clk);
        chk("held_select_tail", 32'(sl_ack), 32'd0);

        wr(0, 32'h00000001, 4'b1110);
        rd_chk(0);

        miss_access(BASE - 32'd4, 1'b0);
        miss_access(HIGH + 32'd1, 1'b1);
        rd_chk(0);

        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 9);
            if (op < 4) begin
                w = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 7);
                xfer(w, 1'b1, 32'd0, 4'hF, 1'($urandom_range(0, 1)), rand_data(), d);
            end else if (op < 7) begin
                w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
                xfer(w, 1'b0, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), rand_data(), d);
            end else if (op < 9) begin
                snap_pulse(rand_data());
            end else begin
                miss_access(($urandom_range(0, 1) == 1) ? HIGH + 32'(4 * $urandom_range(1, 8))
                                                       : BASE - 32'(4 * $urandom_range(1, 8)),
                            1'($urandom_range(0, 1)));
            end
        end
        for (int i = 0; i < 6; i++) rd_chk(i);

        // Reset landing in the hit cycle of a CTRL write
        @(posedge clk) #1;
        abus = BASE;
        rnw  = 1'b0;
        dbus = 32'h00000001;
        be   = 4'hF;
        sel  = 1'b1;
        rst  = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_ack0", 32'(sl_ack), 32'd0);
        @(posedge clk) #1;
        sel = 1'b0;
        rst = 1'b0;
        rnw = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_ack1", 32'(sl_ack), 32'd0);
        model_reset();
        for (int i = 0; i < 6; i++) rd_chk(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opb_status_bank.md
OPB_STATUS_BANK -- requirements
Module: opb_status_bank

Interface
REQ-001 Parameter C_BASEADDR, default 32'h01000100, first byte address of the block's OPB window.
REQ-002 Parameter C_HIGHADDR, default 32'h010001FF, last byte address of the window.
REQ-003 Parameter C_NUM_REGS, default 4, range 1..16, number of 32-bit user channels.
REQ-004 Parameter C_OPB_AWIDTH, default 32; C_OPB_DWIDTH, default 32; C_FAMILY, default "virtex5".
REQ-005 One clock, OPB_Clk; reset OPB_Rst is synchronous and active-high.
REQ-006 Port list (name  direction  width  meaning):
- OPB_Clk  in  1  sole clock.
- OPB_Rst  in  1  synchronous active-high reset.
- OPB_ABus  in  [0:31]  byte address.
- OPB_BE  in  [0:3]  byte enables.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_data_in  in  [C_NUM_REGS*32-1:0]  channel k occupies bits [32k+31:32k].
- user_valid  in  1  snapshot strobe, OPB_Clk domain.

Function
REQ-007 Hit = OPB_select AND C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word index = (OPB_ABus - C_BASEADDR) >> 2.
REQ-008 Address map:
- word 0: CTRL. Bit 31 = freeze (R/W). Bit 30 = missed (read; write-1-to-clear). Other bits read 0.
- word 1: SNAP_CNT, read-only.
- words 2..C_NUM_REGS+1: shadow channel 0..C_NUM_REGS-1, read-only.
- All other words in the window read 0; writes to them are ignored.
REQ-009 Sl_xferAck asserts for exactly one cycle, the cycle after the first cycle of a hit; it never asserts on two consecutive cycles, even if OPB_select stays high.
REQ-010 When OPB_select is held after an ack, the next ack follows 2 cycles later.
REQ-011 Read data is sampled from the registers in the hit cycle and driven on Sl_DBus only while Sl_xferAck = 1; Sl_DBus = 0 otherwise.
REQ-012 A write takes effect in the ack cycle, and only if OPB_BE[3] = 1.
- Write to CTRL: freeze <= OPB_DBus[31]; missed is cleared if OPB_DBus[30] = 1.
REQ-013 Snapshot: user_valid = 1 with freeze = 0 loads all C_NUM_REGS shadows atomically on the next edge, and SNAP_CNT increments by 1.
REQ-014 SNAP_CNT wraps from 32'hFFFFFFFF to 0.
REQ-015 user_valid = 1 with freeze = 1: shadows and SNAP_CNT hold, and missed is set (sticky).
REQ-016 If a snapshot and a read hit occur in the same cycle, the read returns the pre-snapshot value.
REQ-017 If set-missed and a W1C clear occur in the same cycle, set wins: missed = 1.
REQ-018 If a freeze write and user_valid occur in the same cycle, the freeze value before the write governs that user_valid.
REQ-019 Misses (select without hit) produce no ack and no state change.

Reset
REQ-020 On OPB_Rst = 1 at a clock edge, all of the following clear to 0: shadows, SNAP_CNT, freeze, missed, Sl_xferAck, Sl_DBus, and the internal ack-pending state.
REQ-021 Reset asserted mid-transfer suppresses any pending ack; the transfer is dropped with no write effect.
REQ-022 OPB_Rst overrides user_valid and writes in the same cycle.

Verification
REQ-023 Reset, then read words 0..5 (C_NUM_REGS = 4) -> all read 0; each ack is 1 cycle wide, 1 cycle after select.
REQ-024 Drive channels 0..3 = 32'hA0..32'hA3 and pulse user_valid once -> words 2..5 read A0..A3; SNAP_CNT reads 1.
REQ-025 Write CTRL = 32'h00000001, then pulse user_valid with new data -> shadows unchanged, SNAP_CNT unchanged, CTRL reads 32'h00000003. Write CTRL = 32'h00000002 -> CTRL reads 0.
REQ-026 Force SNAP_CNT to 32'hFFFFFFFF via 2^32-1 strobes (or a backdoor) and pulse user_valid -> SNAP_CNT reads 0.
REQ-027 Hold OPB_select high for 6 cycles on word 2 -> acks in cycles 2, 4 and 6 only. Separately, issue a write with OPB_BE = 4'b1110 to CTRL -> freeze stays 0.
REQ-028 Assert OPB_Rst in the cycle between select and ack -> no ack, and all registers read 0 afterwards.
